// File: rtl/multi_pulse_gen.sv
// -----------------------------------------------------------------------------
// multi_pulse_gen
//
// Multi-channel pulse generator. Each channel watches its SP trigger input for
// a rising edge and then drives STEP high for exactly max(LEN,1) clocks. After
// the pulse it optionally waits GAP clocks in a hold-off state before it will
// accept another trigger. Triggers that cannot be served set a sticky MISS bit.
// DONE strobes for one cycle in the first low cycle after a completed pulse.
//
// Optional feature (compile-time macro PULSE_SP_SYNC_EN):
//   defined     - each SP bit goes through a 2-flop synchronizer (reset to 1)
//                 ahead of edge detection; SP may be asynchronous and the
//                 trigger-to-STEP latency is 3 cycles.
//   not defined - SP feeds edge detection directly; SP must be synchronous to
//                 CLK and the trigger-to-STEP latency is 1 cycle.
//
// Parameters:
//   NUM_CH    number of independent channels
//   CNT_W     width of LEN, GAP and the per-channel counters
//
// Ports:
//   CLK       system clock
//   RST       synchronous reset, active-high
//   SP        [NUM_CH] trigger inputs
//   LEN       [CNT_W]  pulse length in clocks, sampled when a pulse is loaded
//   GAP       [CNT_W]  hold-off length in clocks, sampled when a pulse ends
//   RETRIG    1 = a trigger during ON restarts the pulse; 0 = it is dropped
//   MISS_CLR  clears all MISS bits (a same-cycle set wins)
//   STEP      [NUM_CH] pulse outputs
//   BUSY      [NUM_CH] channel is in ON or HOLD
//   DONE      [NUM_CH] one-cycle end-of-pulse strobe
//   MISS      [NUM_CH] sticky dropped-trigger flag
// -----------------------------------------------------------------------------
module multi_pulse_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] SP,
  input  logic [CNT_W-1:0]  LEN,
  input  logic [CNT_W-1:0]  GAP,
  input  logic              RETRIG,
  input  logic              MISS_CLR,
  output logic [NUM_CH-1:0] STEP,
  output logic [NUM_CH-1:0] BUSY,
  output logic [NUM_CH-1:0] DONE,
  output logic [NUM_CH-1:0] MISS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // A zero length would leave the counter with nothing to count down from,
  // so it is treated as a single-cycle pulse.
  logic [CNT_W-1:0] len_eff;
  assign len_eff = (LEN == CNT_ZERO) ? CNT_ONE : LEN;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
      logic             sp_src;
      logic             sp_dly_reg;
      logic             trig;
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             done_reg;
      logic             done_next;
      logic             miss_reg;
      logic             miss_next;
      logic             miss_set;
      logic             step_c;
      logic             busy_c;

`ifdef PULSE_SP_SYNC_EN
      // Synchronizer flops reset high so that an SP already high when reset
      // releases is not mistaken for a fresh edge.
      logic sync1_reg;
      logic sync2_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= SP[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign sp_src = sync2_reg;
`else
      assign sp_src = SP[gi];
`endif

      // Delay register resets high: an SP held through reset never fires.
      always_ff @(posedge CLK) begin
        if (RST) begin
          sp_dly_reg <= 1'b1;
        end else begin
          sp_dly_reg <= sp_src;
        end
      end

      assign trig = sp_src & ~sp_dly_reg;

      // State register
      always_ff @(posedge CLK) begin
        if (RST) begin
          state_reg <= S_IDLE;
          cnt_reg   <= CNT_ZERO;
          done_reg  <= 1'b0;
          miss_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          done_reg  <= done_next;
          miss_reg  <= miss_next;
        end
      end

      // Next-state logic
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        miss_set   = 1'b0;
        case (state_reg)
          S_IDLE: begin
            if (trig) begin
              state_next = S_ON;
              cnt_next   = len_eff;
            end
          end
          S_ON: begin
            if (trig && RETRIG) begin
              // Restart wins over the natural end of the pulse, and the
              // interrupted pulse produces no DONE.
              cnt_next = len_eff;
            end else begin
              if (trig) begin
                miss_set = 1'b1;
              end
              if (cnt_reg == CNT_ONE) begin
                done_next = 1'b1;
                if (GAP == CNT_ZERO) begin
                  state_next = S_IDLE;
                  cnt_next   = CNT_ZERO;
                end else begin
                  state_next = S_HOLD;
                  cnt_next   = GAP;
                end
              end else begin
                cnt_next = cnt_reg - CNT_ONE;
              end
            end
          end
          S_HOLD: begin
            if (trig) begin
              miss_set = 1'b1;
            end
            if (cnt_reg == CNT_ONE) begin
              state_next = S_IDLE;
              cnt_next   = CNT_ZERO;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          default: begin
            state_next = S_IDLE;
            cnt_next   = CNT_ZERO;
          end
        endcase
        // A new drop in the same cycle as MISS_CLR keeps the flag set.
        miss_next = miss_set | (miss_reg & ~MISS_CLR);
      end

      // Output logic
      always_comb begin
        step_c = (state_reg == S_ON);
        busy_c = (state_reg != S_IDLE);
      end

      assign STEP[gi] = step_c;
      assign BUSY[gi] = busy_c;
      assign DONE[gi] = done_reg;
      assign MISS[gi] = miss_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_pulse_gen
//
// Directed self-checking bench for multi_pulse_gen. Each test records per-cycle
// output waveforms into bit vectors (bit k = value in cycle k relative to the
// SP rising edge in cycle 0) and compares them to hand-derived masks. LAT is
// the trigger-to-STEP latency, so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_multi_pulse_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 26;
`ifdef PULSE_SP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] sp;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  gap;
  logic              retrig;
  logic              miss_clr;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] miss;

  int compared;
  int mismatched;

  logic [63:0] step_w;
  logic [63:0] busy_w;
  logic [63:0] done_w;
  logic [63:0] miss_w;
  logic [63:0] exp_w;
  logic [63:0] ch_step_w [NUM_CH];
  logic [63:0] ch_done_w [NUM_CH];

  multi_pulse_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .SP      (sp),
    .LEN     (len),
    .GAP     (gap),
    .RETRIG  (retrig),
    .MISS_CLR(miss_clr),
    .STEP    (step),
    .BUSY    (busy),
    .DONE    (done),
    .MISS    (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits lo .. lo+n-1 set.
  function automatic logic [63:0] span(input int lo, input int n);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k < lo + n; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic settle();
    sp = '0;
    miss_clr = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset();
    sp = '0; len = 26'd5; gap = '0; retrig = 1'b0; miss_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    compared++;
    if (step !== 4'h0) begin mismatched++; $display("FAIL reset_step: got %h want 0", step); end
    compared++;
    if (busy !== 4'h0) begin mismatched++; $display("FAIL reset_busy: got %h want 0", busy); end
    compared++;
    if (done !== 4'h0) begin mismatched++; $display("FAIL reset_done: got %h want 0", done); end
    compared++;
    if (miss !== 4'h0) begin mismatched++; $display("FAIL reset_miss: got %h want 0", miss); end
    $display("test_reset: outputs step=%h busy=%h done=%h miss=%h", step, busy, done, miss);
  endtask

  task automatic test_basic();
    logic [63:0] other_w;
    len = 26'd5; gap = '0; retrig = 1'b0;
    step_w = '0; busy_w = '0; done_w = '0; other_w = '0;
    for (int i = 0; i < 20; i++) begin
      sp = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
      step_w[i+1]  = step[0];
      busy_w[i+1]  = busy[0];
      done_w[i+1]  = done[0];
      other_w[i+1] = |step[3:1];
    end
    compared++;
    if (step_w !== span(LAT, 5)) begin mismatched++; $display("FAIL basic_step: got %h want %h", step_w, span(LAT, 5)); end
    compared++;
    if (done_w !== span(LAT + 5, 1)) begin mismatched++; $display("FAIL basic_done: got %h want %h", done_w, span(LAT + 5, 1)); end
    compared++;
    if (busy_w !== span(LAT, 5)) begin mismatched++; $display("FAIL basic_busy: got %h want %h", busy_w, span(LAT, 5)); end
    compared++;
    if (other_w !== 64'd0) begin mismatched++; $display("FAIL basic_other_ch: got %h want 0", other_w); end
    $display("test_basic: LEN=5 step=%h done=%h", step_w, done_w);
    settle();
  endtask

  task automatic test_len_zero();
    gap = '0; retrig = 1'b0;
    for (int t = 0; t < 2; t++) begin
      len = CNT_W'(t);
      step_w = '0; done_w = '0;
      for (int i = 0; i < 12; i++) begin
        sp = (i == 0) ? 4'b0001 : 4'b0000;
        tick();
        step_w[i+1] = step[0];
        done_w[i+1] = done[0];
      end
      compared++;
      if (step_w !== span(LAT, 1)) begin mismatched++; $display("FAIL len%0d_step: got %h want %h", t, step_w, span(LAT, 1)); end
      compared++;
      if (done_w !== span(LAT + 1, 1)) begin mismatched++; $display("FAIL len%0d_done: got %h want %h", t, done_w, span(LAT + 1, 1)); end
      $display("test_len_zero: LEN=%0d step=%h done=%h", t, step_w, done_w);
      settle();
    end
  endtask

  task automatic test_retrigger();
    len = 26'd8; gap = '0;
    // RETRIG=1: second edge in cycle 4 restarts the pulse -> 12 cycles
    retrig = 1'b1;
    step_w = '0; done_w = '0;
    for (int i = 0; i < 24; i++) begin
      sp = (i == 0 || i == 4) ? 4'b0010 : 4'b0000;
      tick();
      step_w[i+1] = step[1];
      done_w[i+1] = done[1];
    end
    compared++;
    if (step_w !== span(LAT, 12)) begin mismatched++; $display("FAIL retrig1_step: got %h want %h", step_w, span(LAT, 12)); end
    compared++;
    if (done_w !== span(LAT + 12, 1)) begin mismatched++; $display("FAIL retrig1_done: got %h want %h", done_w, span(LAT + 12, 1)); end
    compared++;
    if (miss[1] !== 1'b0) begin mismatched++; $display("FAIL retrig1_miss: got %b want 0", miss[1]); end
    $display("test_retrigger: RETRIG=1 step=%h done=%h miss=%b", step_w, done_w, miss[1]);
    settle();
    // RETRIG=0: second edge dropped -> 8 cycles, MISS set
    retrig = 1'b0;
    step_w = '0; done_w = '0;
    for (int i = 0; i < 24; i++) begin
      sp = (i == 0 || i == 4) ? 4'b0010 : 4'b0000;
      tick();
      step_w[i+1] = step[1];
      done_w[i+1] = done[1];
    end
    compared++;
    if (step_w !== span(LAT, 8)) begin mismatched++; $display("FAIL retrig0_step: got %h want %h", step_w, span(LAT, 8)); end
    compared++;
    if (done_w !== span(LAT + 8, 1)) begin mismatched++; $display("FAIL retrig0_done: got %h want %h", done_w, span(LAT + 8, 1)); end
    compared++;
    if (miss !== 4'b0010) begin mismatched++; $display("FAIL retrig0_miss: got %h want 2", miss); end
    for (int k = 0; k < 3; k++) tick();
    compared++;
    if (miss !== 4'b0010) begin mismatched++; $display("FAIL retrig0_miss_sticky: got %h want 2", miss); end
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    compared++;
    if (miss !== 4'b0000) begin mismatched++; $display("FAIL retrig0_miss_clr: got %h want 0", miss); end
    $display("test_retrigger: RETRIG=0 step=%h done=%h miss after clr=%h", step_w, done_w, miss);
    settle();
  endtask

  task automatic test_holdoff();
    // ON LAT..LAT+2, HOLD LAT+3..LAT+6; edge in cycle 5 lands in HOLD,
    // edge in cycle 8 lands in the first IDLE cycle.
    len = 26'd3; gap = 26'd4; retrig = 1'b1;
    step_w = '0; busy_w = '0; done_w = '0; miss_w = '0;
    for (int i = 0; i < 24; i++) begin
      sp = (i == 0 || i == 5 || i == 8) ? 4'b0100 : 4'b0000;
      tick();
      step_w[i+1] = step[2];
      busy_w[i+1] = busy[2];
      done_w[i+1] = done[2];
      miss_w[i+1] = miss[2];
    end
    compared++;
    exp_w = span(LAT, 3) | span(LAT + 8, 3);
    if (step_w !== exp_w) begin mismatched++; $display("FAIL hold_step: got %h want %h", step_w, exp_w); end
    compared++;
    exp_w = span(LAT, 7) | span(LAT + 8, 7);
    if (busy_w !== exp_w) begin mismatched++; $display("FAIL hold_busy: got %h want %h", busy_w, exp_w); end
    compared++;
    exp_w = span(LAT + 3, 1) | span(LAT + 11, 1);
    if (done_w !== exp_w) begin mismatched++; $display("FAIL hold_done: got %h want %h", done_w, exp_w); end
    compared++;
    exp_w = span(LAT + 5, 24 - (LAT + 5) + 1);
    if (miss_w !== exp_w) begin mismatched++; $display("FAIL hold_miss: got %h want %h", miss_w, exp_w); end
    $display("test_holdoff: step=%h busy=%h done=%h miss=%h", step_w, busy_w, done_w, miss_w);
    settle();
  endtask

  task automatic test_miss_priority();
    logic miss_after;
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    compared++;
    if (miss !== 4'b0000) begin mismatched++; $display("FAIL prio_preclear: got %h want 0", miss); end
    settle();
    len = 26'd3; gap = 26'd4; retrig = 1'b0;
    miss_after = 1'b0;
    // Trigger reaches the FSM in cycle LAT+4 (HOLD); MISS_CLR in that cycle too.
    for (int i = 0; i < 16; i++) begin
      sp = (i == 0 || i == 5) ? 4'b0100 : 4'b0000;
      miss_clr = (i == LAT + 4) ? 1'b1 : 1'b0;
      tick();
      if (i + 1 == LAT + 5) miss_after = miss[2];
    end
    miss_clr = 1'b0;
    compared++;
    if (miss_after !== 1'b1) begin mismatched++; $display("FAIL prio_set_wins: got %b want 1", miss_after); end
    $display("test_miss_priority: miss after same-cycle set/clr=%b", miss_after);
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    len = 26'd10; gap = '0; retrig = 1'b0;
    step_w = '0; done_w = '0;
    for (int i = 0; i < 20; i++) begin
      sp = (i == 0) ? 4'b0001 : 4'b0000;
      rst = (i == LAT + 2) ? 1'b1 : 1'b0;
      tick();
      step_w[i+1] = step[0];
      done_w[i+1] = done[0];
    end
    rst = 1'b0;
    compared++;
    if (step_w !== span(LAT, 3)) begin mismatched++; $display("FAIL rstmid_step: got %h want %h", step_w, span(LAT, 3)); end
    compared++;
    if (done_w !== 64'd0) begin mismatched++; $display("FAIL rstmid_done: got %h want 0", done_w); end
    $display("test_reset_mid: step=%h done=%h", step_w, done_w);
    settle();
  endtask

  task automatic test_sp_held();
    len = 26'd4; gap = '0;
    sp = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    step_w = '0; busy_w = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      step_w[i+1] = |step;
      busy_w[i+1] = |busy;
    end
    compared++;
    if (step_w !== 64'd0) begin mismatched++; $display("FAIL held_step: got %h want 0", step_w); end
    compared++;
    if (busy_w !== 64'd0) begin mismatched++; $display("FAIL held_busy: got %h want 0", busy_w); end
    $display("test_sp_held: step=%h busy=%h", step_w, busy_w);
    settle();
  endtask

  task automatic test_multi_same();
    len = 26'd6; gap = '0; retrig = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin ch_step_w[c] = '0; ch_done_w[c] = '0; end
    for (int i = 0; i < 16; i++) begin
      sp = (i == 0) ? 4'hF : 4'h0;
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        ch_step_w[c][i+1] = step[c];
        ch_done_w[c][i+1] = done[c];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      compared++;
      if (ch_step_w[c] !== span(LAT, 6)) begin mismatched++; $display("FAIL multi_same_step%0d: got %h want %h", c, ch_step_w[c], span(LAT, 6)); end
      compared++;
      if (ch_done_w[c] !== span(LAT + 6, 1)) begin mismatched++; $display("FAIL multi_same_done%0d: got %h want %h", c, ch_done_w[c], span(LAT + 6, 1)); end
    end
    $display("test_multi_same: ch0 step=%h ch3 step=%h", ch_step_w[0], ch_step_w[3]);
    settle();
  endtask

  task automatic test_multi_staggered();
    int sp_at [NUM_CH];
    int len_of [NUM_CH];
    sp_at  = '{0, 2, 5, 9};
    len_of = '{4, 2, 6, 3};
    gap = '0; retrig = 1'b0;
    len = 26'd4;
    for (int c = 0; c < NUM_CH; c++) ch_step_w[c] = '0;
    // LEN is changed exactly in each channel's trigger cycle, so running
    // pulses see LEN change underneath them.
    for (int i = 0; i < 24; i++) begin
      sp = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (i == sp_at[c]) sp[c] = 1'b1;
        if (i == sp_at[c] + LAT - 1) len = CNT_W'(len_of[c]);
      end
      tick();
      for (int c = 0; c < NUM_CH; c++) ch_step_w[c][i+1] = step[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      compared++;
      exp_w = span(sp_at[c] + LAT, len_of[c]);
      if (ch_step_w[c] !== exp_w) begin mismatched++; $display("FAIL multi_stag_step%0d: got %h want %h", c, ch_step_w[c], exp_w); end
    end
    $display("test_multi_staggered: steps %h %h %h %h", ch_step_w[0], ch_step_w[1], ch_step_w[2], ch_step_w[3]);
    settle();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    sp = '0;
    len = '0;
    gap = '0;
    retrig = 1'b0;
    miss_clr = 1'b0;
    test_reset();
    settle();
    test_basic();
    test_len_zero();
    test_retrigger();
    test_holdoff();
    test_miss_priority();
    test_reset_mid();
    test_sp_held();
    test_multi_same();
    test_multi_staggered();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
- Multi-channel successor to the single-pulse LED/step generator.
- Each of NUM_CH channels detects a rising edge on its SP input and drives a STEP pulse exactly LEN clocks long.
- Adds runtime pulse length, an optional retrigger mode, a post-pulse hold-off gap, a missed-trigger flag and an end-of-pulse strobe.
- Sits between push-button/trigger inputs and step/LED drivers.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 26: width of LEN, GAP and the internal counters (covers 50,000,000 at 50 MHz).

Ports:
- CLK  in  1  system clock (50 MHz).
- RST  in  1  synchronous reset, active-high.
- SP  in  NUM_CH  trigger inputs, one per channel, synchronous to CLK.
- LEN  in  CNT_W  pulse length in clocks, shared by all channels, sampled at trigger.
- GAP  in  CNT_W  hold-off length in clocks, sampled on pulse end.
- RETRIG  in  1  0 = ignore triggers while busy; 1 = restart the pulse on a trigger during ON.
- MISS_CLR  in  1  clears all MISS bits.
- STEP  out  NUM_CH  pulse outputs.
- BUSY  out  NUM_CH  channel is in ON or HOLD.
- DONE  out  NUM_CH  one-cycle strobe, asserted in the first cycle STEP is low after a pulse.
- MISS  out  NUM_CH  sticky flag: a trigger was dropped.

Behaviour:
- Reset is synchronous, active-high, evaluated on the CLK rising edge.
- Reset values:
  - STEP, BUSY, DONE, MISS = 0.
  - All channels in IDLE; all counters = 0.
  - Edge-detect delay registers = 1, so an SP held high through reset never fires.
- Edge detect per channel: trig = SP & ~sp_dly, where sp_dly is SP registered.
- Per-channel FSM: IDLE, ON, HOLD. STEP = (state == ON); BUSY = (state != IDLE).
- IDLE:
  - On trig: go to ON and load cnt = max(LEN,1).
  - Latency: SP high in cycle c (low in c-1) gives STEP high from cycle c+1.
- ON:
  - cnt decrements each cycle; STEP stays high for exactly max(LEN,1) cycles.
  - When cnt == 1 with no reload: go to HOLD and load GAP, or go to IDLE if GAP == 0. DONE = 1 in the next cycle.
- Trigger during ON with RETRIG = 1:
  - Reload cnt = max(LEN,1) using the current LEN value.
  - STEP stays high until LEN cycles after the trigger cycle; no DONE is issued for the interrupted pulse.
  - If the reload coincides with cnt == 1, the reload wins.
- Trigger during ON with RETRIG = 0: trigger is dropped and MISS is set.
- HOLD:
  - cnt counts GAP cycles down, then the channel returns to IDLE.
  - Any trig during HOLD is dropped and MISS is set, regardless of RETRIG.
  - A trig in the first IDLE cycle after HOLD is accepted.
- MISS:
  - Set has priority over MISS_CLR in the same cycle.
  - Cleared only by MISS_CLR or RST.
- Channels are fully independent; simultaneous triggers on all channels are all served in the same cycle.
- LEN is sampled only at load time, so changing it mid-pulse does not affect a running pulse.
- Reset asserted mid-pulse: STEP drops in the next cycle and no DONE is issued.
- Counter arithmetic is unsigned CNT_W bits. A value of 0 is never decremented: LEN = 0 is clamped to 1, and GAP = 0 skips HOLD.

Optional Feature:
- Macro: PULSE_SP_SYNC_EN.
- Defined:
  - Each SP bit passes through a 2-flop synchronizer (reset to 1) before edge detection.
  - Trigger latency becomes 3 cycles: SP high in cycle c gives STEP in cycle c+3.
  - SP may be asynchronous.
- Not defined:
  - SP goes straight to edge detection with 1-cycle latency.
  - SP must be synchronous to CLK.

Test Plan:
- Basic pulse: LEN = 5, GAP = 0, ch0 SP 0→1 in cycle 10 → STEP[0] high in cycles 11–15, DONE[0] in cycle 16, BUSY[0] low in 16.
- LEN = 0: trigger → STEP high for exactly 1 cycle; LEN = 1 gives the identical result.
- Retrigger: LEN = 8, RETRIG = 1, second edge 4 cycles into the pulse → 12 contiguous STEP cycles, one DONE, MISS = 0. Repeat with RETRIG = 0 → 8 cycles and MISS = 1 until MISS_CLR.
- Hold-off: LEN = 3, GAP = 4, edge during HOLD → dropped, MISS set; edge in the first IDLE cycle → new pulse. Same-cycle set and MISS_CLR → MISS stays 1.
- Reset: RST pulsed in cycle 3 of a LEN = 10 pulse → STEP = 0 next cycle, no DONE. SP held high across reset release → no pulse.
- Multi-channel: 4 channels triggered in the same cycle with LEN = 6 → identical STEP waveforms; staggered triggers are independent. Repeat with PULSE_SP_SYNC_EN defined → each output shifted 2 cycles later.
